// File: rtl/prefix_sub_pipe.sv
// Two-stage pipelined subtractor D = X - Y, computed as X + ~Y + 1 on a
// Kogge-Stone style generate/propagate prefix network. Stage 1 registers
// the first half of the prefix levels; stage 2 finishes the carries and
// registers D, the borrow flag Bo and the signed overflow flag Ov.
//
// Handshake: a transfer happens on any rising edge where valid and ready
// are both 1. in_ready = ~s1_valid | s1_adv with s1_adv = ~out_valid |
// out_ready, so in_ready depends combinationally on out_ready but nothing
// ties in_valid combinationally to out_valid. Output data hold while
// out_valid & ~out_ready.
module prefix_sub_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Bo,
   output logic             Ov
);

   localparam int L   = $clog2(WIDTH);   // total prefix levels
   localparam int L1  = (L + 1) / 2;     // levels evaluated before the stage-1 register
   localparam int NL2 = L - L1;          // levels evaluated in stage 2

   // Stage 1 state
   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_h_q, s1_h_d;
   logic [WIDTH-1:0] s1_g_q;
   logic [WIDTH-1:0] s1_p_q;
   logic             s1_xs_q, s1_ys_q;

   // Stage 2 (output) state
   logic             out_valid_q;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bo_q, bo_d;
   logic             ov_q, ov_d;

   logic             s1_adv;
   logic             in_xfer;

   // Prefix network arrays: index 0 is the level input
   logic [WIDTH-1:0] g1 [0:L1];
   logic [WIDTH-1:0] p1 [0:L1];
   logic [WIDTH-1:0] g2 [0:NL2];
   logic [WIDTH-1:0] p2 [0:NL2];
   logic [WIDTH-1:0] carry;
   logic             unused_p;

   // ---------------- flow control ----------------
   assign s1_adv   = ~out_valid_q | out_ready;
   assign in_ready = ~s1_valid_q | s1_adv;
   assign in_xfer  = in_valid & in_ready;

   // ---------------- stage 1 combinational ----------------
   // Subtract as X + ~Y + 1: bit-level generate/propagate, with the constant
   // carry-in of 1 folded into bit 0 (g0' = g0 | p0).
   assign s1_h_d = X ^ ~Y;
   assign p1[0]  = X | ~Y;
   assign g1[0]  = {X[WIDTH-1:1] & ~Y[WIDTH-1:1],
                    (X[0] & ~Y[0]) | (X[0] | ~Y[0])};

   for (genvar lv = 0; lv < L1; lv++) begin : g_s1_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= (1 << lv)) begin : g_op
            assign g1[lv+1][i] = g1[lv][i] | (p1[lv][i] & g1[lv][i-(1<<lv)]);
            assign p1[lv+1][i] = p1[lv][i] & p1[lv][i-(1<<lv)];
         end else begin : g_pass
            assign g1[lv+1][i] = g1[lv][i];
            assign p1[lv+1][i] = p1[lv][i];
         end
      end
   end

   // ---------------- stage 2 combinational ----------------
   assign g2[0] = s1_g_q;
   assign p2[0] = s1_p_q;

   for (genvar lv = 0; lv < NL2; lv++) begin : g_s2_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= (1 << (lv + L1))) begin : g_op
            assign g2[lv+1][i] = g2[lv][i] | (p2[lv][i] & g2[lv][i-(1<<(lv+L1))]);
            assign p2[lv+1][i] = p2[lv][i] & p2[lv][i-(1<<(lv+L1))];
         end else begin : g_pass
            assign g2[lv+1][i] = g2[lv][i];
            assign p2[lv+1][i] = p2[lv][i];
         end
      end
   end

   // Final-level group propagates do not feed any carry.
   assign unused_p = ^p2[NL2];

   // c[0] = 1 (carry-in), c[i] = group generate of bits i-1..0
   assign carry = {g2[NL2][WIDTH-2:0], 1'b1};
   assign d_d   = s1_h_q ^ carry;
   assign bo_d  = ~g2[NL2][WIDTH-1];
   assign ov_d  = (s1_xs_q != s1_ys_q) && (d_d[WIDTH-1] != s1_xs_q);

   // Stage 1 register: loads on an input transfer, empties when it advances
   // with nothing new behind it.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_h_q     <= '0;
         s1_g_q     <= '0;
         s1_p_q     <= '0;
         s1_xs_q    <= 1'b0;
         s1_ys_q    <= 1'b0;
      end else if (in_xfer) begin
         s1_valid_q <= 1'b1;
         s1_h_q     <= s1_h_d;
         s1_g_q     <= g1[L1];
         s1_p_q     <= p1[L1];
         s1_xs_q    <= X[WIDTH-1];
         s1_ys_q    <= Y[WIDTH-1];
      end else if (s1_adv) begin
         s1_valid_q <= 1'b0;
      end
   end

   // Stage 2 register: loads from stage 1 when it advances, otherwise empties
   // once the held result is accepted; data hold during a stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         d_q         <= '0;
         bo_q        <= 1'b0;
         ov_q        <= 1'b0;
      end else if (s1_valid_q && s1_adv) begin
         out_valid_q <= 1'b1;
         d_q         <= d_d;
         bo_q        <= bo_d;
         ov_q        <= ov_d;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign D         = d_q;
   assign Bo        = bo_q;
   assign Ov        = ov_q;

endmodule

// File: tb/tb_prefix_sub_pipe.sv
// Bench for prefix_sub_pipe: per-scenario tasks with inline checks, plus a
// monitor that keeps an expected-result queue (filled on every input
// transfer, drained on every output transfer) and checks output stability
// while stalled. Inputs change on the falling edge; the monitor samples 1 ns
// before each rising edge.
module tb_prefix_sub_pipe;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] X;
   logic [W-1:0] Y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] D;
   logic         Bo;
   logic         Ov;

   int n_cmp = 0;
   int n_err = 0;
   int n_pop = 0;

   logic [W+1:0] exp_q[$];     // {Ov, Bo, D}
   logic         prev_stall = 1'b0;
   logic [W+1:0] prev_out   = '0;

   prefix_sub_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .X         (X),
      .Y         (Y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (D),
      .Bo        (Bo),
      .Ov        (Ov)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {~Bo, D} = X + ~Y + 1; Ov from operand signs and result sign.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] s;
      logic       bo;
      logic       ov;
      s  = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
      bo = ~s[W];
      ov = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
      return {ov, bo, s[W-1:0]};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [W+1:0] e;
      #4;
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_cmp++;
            if (!out_valid || {Ov, Bo, D} !== prev_out) begin
               n_err++;
               $display("FAIL hold: got valid=%0b out=%h, required valid=1 out=%h",
                        out_valid, {Ov, Bo, D}, prev_out);
            end
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            n_pop++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_output: got {Ov,Bo,D}=%h with nothing expected",
                        {Ov, Bo, D});
            end else begin
               e = exp_q.pop_front();
               if ({Ov, Bo, D} !== e) begin
                  n_err++;
                  $display("FAIL scoreboard: got {Ov,Bo,D}=%h, required %h", {Ov, Bo, D}, e);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(X, Y));
         prev_stall = out_valid && !out_ready;
         prev_out   = {Ov, Bo, D};
      end
   end

   // ---------------- driver helpers ----------------
   task automatic drive_idle();
      in_valid = 1'b0;
      X        = 'x;
      Y        = 'x;
   endtask

   task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y);
      in_valid = 1'b1;
      X        = x;
      Y        = y;
   endtask

   // One isolated operation with out_ready=1, checking timing and value.
   task automatic do_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ed, input logic ebo, input logic eov);
      @(negedge clk);
      out_ready = 1'b1;
      drive_op(x, y);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s_in_ready: got %b, required 1", name, in_ready);
      end
      @(negedge clk);
      drive_idle();
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s_early: out_valid got %b, required 0", name, out_valid);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || D !== ed || Bo !== ebo || Ov !== eov) begin
         n_err++;
         $display("FAIL %s: got valid=%b D=%h Bo=%b Ov=%b, required valid=1 D=%h Bo=%b Ov=%b",
                  name, out_valid, D, Bo, Ov, ed, ebo, eov);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s_one_cycle: out_valid got %b, required 0", name, out_valid);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst       = 1'b1;
      out_ready = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || D !== '0 || Bo !== 1'b0 || Ov !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset: got valid=%b D=%h Bo=%b Ov=%b in_ready=%b, required 0 00 0 0 1",
                  out_valid, D, Bo, Ov, in_ready);
      end
   endtask

   task automatic test_single();
      do_op("single", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
   endtask

   task automatic test_borrow_overflow();
      do_op("wrap",     8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
      do_op("overflow", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      do_op("equal",    8'hA7, 8'hA7, 8'h00, 1'b0, 1'b0);
      do_op("neg_ovf",  8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back();
      int gaps;
      int pop0;
      gaps = 0;
      pop0 = n_pop;
      for (int k = 0; k < 258; k++) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (k < 256) drive_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
         else         drive_idle();
         #1;
         if (k < 256 && in_ready !== 1'b1) gaps++;
         if (k >= 2 && out_valid !== 1'b1) gaps++;
      end
      @(negedge clk);
      drive_idle();
      repeat (2) @(negedge clk);
      n_cmp++;
      if (gaps != 0) begin
         n_err++;
         $display("FAIL stream_gaps: got %0d bubble cycles, required 0", gaps);
      end
      n_cmp++;
      if (n_pop - pop0 != 256 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL stream_count: got %0d results (%0d pending), required 256 (0 pending)",
                  n_pop - pop0, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] xs[3];
      logic [W-1:0] ys[3];
      logic [W+1:0] ea;
      int           idx;
      int           pop0;
      xs[0] = 8'h10; ys[0] = 8'h20;
      xs[1] = 8'hC3; ys[1] = 8'h41;
      xs[2] = 8'h7E; ys[2] = 8'h7E;
      ea    = model(xs[0], ys[0]);
      idx   = 0;
      pop0  = n_pop;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         drive_op(xs[idx], ys[idx]);
         #1;
         if (in_ready === 1'b1 && idx < 2) idx++;
      end
      n_cmp++;
      if (idx != 2 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_full: got accepts=%0d in_ready=%b, required accepts=2 in_ready=0",
                  idx, in_ready);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || {Ov, Bo, D} !== ea) begin
         n_err++;
         $display("FAIL bp_head: got valid=%b out=%h, required valid=1 out=%h",
                  out_valid, {Ov, Bo, D}, ea);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: in_ready got %b, required 1", in_ready);
      end
      @(negedge clk);
      drive_idle();
      repeat (5) @(negedge clk);
      n_cmp++;
      if (n_pop - pop0 != 3 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL bp_drain: got %0d results (%0d pending), required 3 (0 pending)",
                  n_pop - pop0, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int ghosts;
      int pop0;
      ghosts = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         drive_op(W'(8'h21 + c), 8'h05);
      end
      @(negedge clk);
      drive_idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL mid_reset: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
      pop0 = n_pop;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         #1;
         if (out_valid !== 1'b0) ghosts++;
      end
      n_cmp++;
      if (ghosts != 0 || n_pop != pop0) begin
         n_err++;
         $display("FAIL mid_reset_ghost: got %0d stale result cycles, required 0", ghosts);
      end
      do_op("after_reset", 8'h33, 8'h44, 8'hEF, 1'b1, 1'b0);
   endtask

   // ---------------- sequence ----------------
   initial begin
      test_reset();
      test_single();
      test_borrow_overflow();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL leftover: got %0d pending results, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Watchdog: the whole sequence is a few hundred cycles.
   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded 100000 ns, required completion");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
